fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 64-bit pipeline, directly upstream of the instruction queue. Holds the fetch PC, issues one instruction-memory request at a time, and pushes each returned 32-bit instruction together with its incremented PC (PC+4) into the queue. It throttles on queue-full, and on a branch/exception redirect it squashes in-flight fetches and flushes the queue.

## Interface
- `RESET_PC`, default 64'h0000_0000_0000_0000: fetch address loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  when 0, no new memory request is issued. In-flight work still completes.
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  64  new fetch address; bits [1:0] are ignored (forced to 0).
- `imem_req`  out  1  request valid.
- `imem_addr`  out  64  request address.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid (in order, ≥1 cycle after accept).
- `imem_rdata`  in  32  instruction word.
- `q_wr_en`  out  1  queue write strobe.
- `q_inst`  out  32  instruction to the queue.
- `q_incr_pc`  out  64  fetched PC + 4.
- `q_full`  in  1  queue-full flag.
- `q_flush`  out  1  one-cycle queue flush pulse (drives the queue's `rst`).

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: PC of the outstanding request.
  - `hold_inst`: 32-bit holding register.
  - `squash`: 1-bit flag marking the in-flight response as stale.
  - `state`: one of IDLE, REQ, WAIT, HOLD.
- At most one request is outstanding at any time.
- **IDLE** (reset state):
  - All outputs are 0.
  - Always moves to REQ on the next cycle.
- **REQ**:
  - `imem_req` = `fetch_en`, `imem_addr` = `pc`.
  - On `imem_req && imem_ready`: `req_pc` <= `pc`, `pc` <= `pc`+4, go to WAIT.
- **WAIT**: on `imem_rvalid`:
  - If `squash`: drop the response, clear `squash`, go to REQ.
  - Else if `!q_full`: `q_wr_en`=1, `q_inst`=`imem_rdata`, `q_incr_pc`=`req_pc`+4, go to REQ.
  - Else: `hold_inst` <= `imem_rdata`, go to HOLD.
- **HOLD**:
  - `imem_req`=0.
  - When `!q_full`: `q_wr_en`=1 with `hold_inst` and `req_pc`+4, go to REQ.
- **Redirect** (highest priority, any state except IDLE):
  - `pc` <= {`redirect_pc`[63:2], 2'b00}.
  - `q_wr_en` is forced to 0 in that cycle.
  - `q_flush` is 1 in the following cycle.
  - REQ without accept: stay in REQ.
  - REQ with accept in the same cycle: go to WAIT with `squash`=1. `pc` takes the redirect target, not `pc`+4.
  - WAIT: `squash` <= 1, stay in WAIT. If `imem_rvalid` arrives in the same cycle, drop it and go to REQ.
  - HOLD: discard `hold_inst`, go to REQ.
- PC arithmetic is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- `q_wr_en` is never 1 while `q_flush` is 1.

## Timing
- Reset values:
  - `state`=IDLE, `pc`=`RESET_PC`, `squash`=0, `q_flush`=0.
  - `imem_req`, `q_wr_en`, `q_inst`, `q_incr_pc`, `imem_addr` are all 0.
- `rst` asserted mid-operation abandons any outstanding request. Responses arriving after reset are ignored, because the block is in IDLE/REQ.
- The first `imem_req` appears 1 cycle after `rst` deasserts (IDLE→REQ).
- With a 1-cycle memory and no stalls:
  - Accept in cycle N, response and queue write in N+1, next request in N+2.
  - Throughput is 1 instruction per 2 cycles.
- Queue write latency from `imem_rvalid` is 0 cycles (combinational) when the queue is not full.
- `q_flush` is registered: exactly 1 cycle after `redirect_valid`, 1 cycle wide.
- `q_full` is sampled combinationally in the same cycle as the write.

## Test plan
1. **Reset and straight-line fetch.** `RESET_PC`=0x1000, `imem_ready`=1, `rvalid` 1 cycle after accept, `q_full`=0 → requests to 0x1000, 0x1004, 0x1008 every 2 cycles; queue writes carry `q_incr_pc` 0x1004, 0x1008, 0x100C with the matching `imem_rdata`.
2. **Backpressure.** `q_full`=1 when the response for 0x1000 arrives → `q_wr_en`=0, `imem_req`=0 (HOLD). Drop `q_full` 3 cycles later → one write with the held instruction and `q_incr_pc`=0x1004, then a request to 0x1004 on the next cycle.
3. **Redirect while waiting.** Redirect to 0x2000 during WAIT, response arrives 2 cycles later → response dropped, `q_wr_en` never asserted, `q_flush` pulses 1 cycle after the redirect, next request addr 0x2000.
4. **Redirect on accept.** Redirect to 0x3000 in the same cycle the request for 0x1000 is accepted → that response is dropped, next request 0x3000, next write carries `q_incr_pc`=0x3004.
5. **Misaligned redirect and PC wrap.**
   - `redirect_pc`=0x2003 → `imem_addr`=0x2000.
   - Redirect to 0xFFFF_FFFF_FFFF_FFFC → written `q_incr_pc`=0 and the next request addr is 0.
6. **Fetch enable and reset mid-fetch.**
   - `fetch_en`=0 in REQ → `imem_req` stays 0 and `pc` is unchanged.
   - `rst` in WAIT → IDLE, all outputs 0, and the late `rvalid` produces no write.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response, queue write port and redirect input.
// Handshake: a request transfers on a cycle where imem_req && imem_ready are both high; imem_rvalid returns in order, one beat per accepted request.
interface fetch_unit_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        q_wr_en;
    logic [31:0] q_inst;
    logic [63:0] q_incr_pc;
    logic        q_full;
    logic        q_flush;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, q_full,
        output imem_req, imem_addr, q_wr_en, q_inst, q_incr_pc, q_flush
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, q_full,
        input  imem_req, imem_addr, q_wr_en, q_inst, q_incr_pc, q_flush
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, pushes {inst, pc+4} into the queue,
// holds on queue-full, squashes in-flight work and flushes the queue on redirect.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_pc;
    logic [31:0] hold_inst;
    logic        squash;
    logic        flush_r;

    logic        req;
    logic        accept;
    logic [63:0] target;
    logic        wr_en;
    logic [31:0] inst;
    logic [63:0] incr_pc;

    assign req    = (state == REQ) && bus.fetch_en;
    assign accept = req && bus.imem_ready;
    assign target = bus.redirect_pc & ~64'h3;

    // Queue writes are combinational from the response so a non-full queue sees zero latency.
    always_comb begin
        wr_en   = 1'b0;
        inst    = 32'h0;
        incr_pc = 64'h0;
        if (!bus.redirect_valid) begin
            if (state == WAIT && bus.imem_rvalid && !squash && !bus.q_full) begin
                wr_en = 1'b1;
                inst  = bus.imem_rdata;
            end else if (state == HOLD && !bus.q_full) begin
                wr_en = 1'b1;
                inst  = hold_inst;
            end
        end
        if (wr_en) begin
            incr_pc = req_pc + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= 64'h0;
            hold_inst <= 32'h0;
            squash    <= 1'b0;
            flush_r   <= 1'b0;
        end else begin
            flush_r <= bus.redirect_valid && (state != IDLE);
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (accept) begin
                        req_pc <= pc;
                        pc     <= pc + 64'd4;
                        state  <= WAIT;
                    end
                    if (bus.redirect_valid) begin
                        pc <= target;
                        if (accept) squash <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        pc <= target;
                        if (bus.imem_rvalid) begin
                            squash <= 1'b0;
                            state  <= REQ;
                        end else begin
                            squash <= 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= REQ;
                        end else if (!bus.q_full) begin
                            state <= REQ;
                        end else begin
                            hold_inst <= bus.imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (!bus.q_full) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state == REQ) ? pc : 64'h0;
    assign bus.q_wr_en   = wr_en;
    assign bus.q_inst    = inst;
    assign bus.q_incr_pc = incr_pc;
    assign bus.q_flush   = flush_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, backpressure, redirects, wrap, enable and reset.
module tb_fetch_unit;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.q_full         = 1'b0;
    endtask

    // Leaves the DUT in REQ with pc = 0x1000.
    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    // One request accepted at exp_addr, response next cycle, written straight into the queue.
    task automatic fetch_one(input logic [63:0] exp_addr, input logic [31:0] data, input logic [63:0] exp_incr);
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        check("req", {63'h0, bus.imem_req}, 64'h1);
        check("addr", bus.imem_addr, exp_addr);
        next_cycle();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clk);
        check("wr_en", {63'h0, bus.q_wr_en}, 64'h1);
        check("inst", {32'h0, bus.q_inst}, {32'h0, data});
        check("incr_pc", bus.q_incr_pc, exp_incr);
        next_cycle();
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        quiet_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_state", {62'h0, dbg_state}, {62'h0, S_IDLE});
        check("rst_req", {63'h0, bus.imem_req}, 64'h0);
        check("rst_addr", bus.imem_addr, 64'h0);
        check("rst_wr", {63'h0, bus.q_wr_en}, 64'h0);
        check("rst_flush", {63'h0, bus.q_flush}, 64'h0);
        check("rst_incr", bus.q_incr_pc, 64'h0);
        check("rst_inst", {32'h0, bus.q_inst}, 64'h0);

        // Straight-line fetch
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {63'h0, bus.imem_req}, 64'h0);
        next_cycle();
        fetch_one(64'h1000, 32'hAAAA_0001, 64'h1004);
        fetch_one(64'h1004, 32'hAAAA_0002, 64'h1008);
        fetch_one(64'h1008, 32'hAAAA_0003, 64'h100C);

        // Backpressure
        do_reset();
        bus.imem_ready = 1'b1;
        @(negedge clk);
        check("bp_addr", bus.imem_addr, 64'h1000);
        next_cycle();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBBBB_0001;
        bus.q_full      = 1'b1;
        @(negedge clk);
        check("bp_no_wr", {63'h0, bus.q_wr_en}, 64'h0);
        next_cycle();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_state", {62'h0, dbg_state}, {62'h0, S_HOLD});
            check("bp_hold_req", {63'h0, bus.imem_req}, 64'h0);
            check("bp_hold_wr", {63'h0, bus.q_wr_en}, 64'h0);
            next_cycle();
        end
        bus.q_full = 1'b0;
        @(negedge clk);
        check("bp_wr", {63'h0, bus.q_wr_en}, 64'h1);
        check("bp_inst", {32'h0, bus.q_inst}, 64'hBBBB_0001);
        check("bp_incr", bus.q_incr_pc, 64'h1004);
        next_cycle();
        @(negedge clk);
        check("bp_next_req", {63'h0, bus.imem_req}, 64'h1);
        check("bp_next_addr", bus.imem_addr, 64'h1004);

        // Redirect while waiting
        bus.imem_ready = 1'b1;
        next_cycle();
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2000;
        @(negedge clk);
        check("rw_wr_redir", {63'h0, bus.q_wr_en}, 64'h0);
        check("rw_flush_early", {63'h0, bus.q_flush}, 64'h0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("rw_flush", {63'h0, bus.q_flush}, 64'h1);
        check("rw_wr_flush", {63'h0, bus.q_wr_en}, 64'h0);
        next_cycle();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0001;
        @(negedge clk);
        check("rw_drop", {63'h0, bus.q_wr_en}, 64'h0);
        check("rw_flush_off", {63'h0, bus.q_flush}, 64'h0);
        next_cycle();
        bus.imem_rvalid = 1'b0;
        fetch_one(64'h2000, 32'hCCCC_0001, 64'h2004);

        // Redirect on accept
        do_reset();
        bus.imem_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3000;
        @(negedge clk);
        check("ra_addr", bus.imem_addr, 64'h1000);
        next_cycle();
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 32'hDEAD_0002;
        @(negedge clk);
        check("ra_flush", {63'h0, bus.q_flush}, 64'h1);
        check("ra_drop", {63'h0, bus.q_wr_en}, 64'h0);
        next_cycle();
        bus.imem_rvalid = 1'b0;
        fetch_one(64'h3000, 32'hDDDD_0001, 64'h3004);

        // Misaligned redirect, then wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2003;
        next_cycle();
        bus.redirect_valid = 1'b0;
        fetch_one(64'h2000, 32'hEEEE_0001, 64'h2004);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        next_cycle();
        bus.redirect_valid = 1'b0;
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'hEEEE_0002, 64'h0);
        @(negedge clk);
        check("wrap_next_addr", bus.imem_addr, 64'h0);

        // Fetch enable low holds pc
        bus.fetch_en   = 1'b0;
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en_off_req", {63'h0, bus.imem_req}, 64'h0);
            check("en_off_state", {62'h0, dbg_state}, {62'h0, S_REQ});
            next_cycle();
        end
        bus.fetch_en   = 1'b1;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        check("en_on_addr", bus.imem_addr, 64'h0);

        // Reset while waiting; late response ignored
        bus.imem_ready = 1'b1;
        next_cycle();
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0003;
        @(negedge clk);
        check("mr_state", {62'h0, dbg_state}, {62'h0, S_IDLE});
        check("mr_req", {63'h0, bus.imem_req}, 64'h0);
        check("mr_wr", {63'h0, bus.q_wr_en}, 64'h0);
        check("mr_addr", bus.imem_addr, 64'h0);
        next_cycle();
        @(negedge clk);
        check("mr_late_wr", {63'h0, bus.q_wr_en}, 64'h0);
        check("mr_req_addr", bus.imem_addr, 64'h1000);
        bus.imem_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
